// File: rtl/writeback_queue_pkg.sv
// Shared defaults and entry type for the register writeback queue.
package writeback_queue_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 32;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] rd;
    logic [DATA_W_DEF-1:0] val;
  } wb_entry_t;

endpackage

// File: rtl/writeback_queue_match.sv
// Hazard lookup for one query index: pending flag over occupied entries and,
// with WBQ_FORWARD_EN, the value of the youngest matching entry.
module wbq_match #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 6,
  parameter int PTR_W  = $clog2(DEPTH)
`ifdef WBQ_FORWARD_EN
  , parameter int DATA_W = 32
`endif
) (
  input  logic [ADDR_W-1:0] rd_q [DEPTH],
`ifdef WBQ_FORWARD_EN
  input  logic [DATA_W-1:0] val_q [DEPTH],
  output logic [DATA_W-1:0] fwd,
`endif
  input  logic [PTR_W-1:0]  rptr,
  input  logic [PTR_W:0]    count,
  input  logic [ADDR_W-1:0] index,
  output logic              pending
);

  // Walk oldest to youngest so the last hit is the youngest match.
  always_comb begin
    pending = 1'b0;
`ifdef WBQ_FORWARD_EN
    fwd = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      if (((PTR_W+1)'(i) < count) && (rd_q[rptr + PTR_W'(i)] == index)) begin
        pending = 1'b1;
`ifdef WBQ_FORWARD_EN
        fwd = val_q[rptr + PTR_W'(i)];
`endif
      end
    end
  end

endmodule

// File: rtl/writeback_queue.sv
// Two-source register writeback FIFO with round-robin intake and hazard flags.
// Define WBQ_FORWARD_EN to add youngest-match value forwarding outputs.
module writeback_queue
  import writeback_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_alu_valid,
  input  logic [ADDR_W-1:0] in_alu_rd,
  input  logic [DATA_W-1:0] in_alu_val,
  output logic              out_alu_ready,
  input  logic              in_mem_valid,
  input  logic [ADDR_W-1:0] in_mem_rd,
  input  logic [DATA_W-1:0] in_mem_val,
  output logic              out_mem_ready,
  input  logic              in_ctrl_hold,
  output logic              out_ctrl_regwrt,
  output logic [ADDR_W-1:0] out_rd,
  output logic [DATA_W-1:0] out_rdval,
  input  logic [ADDR_W-1:0] in_rs,
  input  logic [ADDR_W-1:0] in_rt,
`ifdef WBQ_FORWARD_EN
  output logic [DATA_W-1:0] out_rs_fwd,
  output logic [DATA_W-1:0] out_rt_fwd,
`endif
  output logic              out_rs_pending,
  output logic              out_rt_pending
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] rd_q  [DEPTH];
  logic [DATA_W-1:0] val_q [DEPTH];
  logic [PTR_W-1:0]  rptr, wptr;
  logic [CNT_W-1:0]  count;
  logic              last_mem, active;
  logic              pop, room, grant_alu, grant_mem, enq;
  logic [ADDR_W-1:0] enq_rd;
  logic [DATA_W-1:0] enq_val;

  // Handshake: a source's request is taken on the rising edge where its
  // valid and ready are both 1; until then the source holds it stable.
  // 'active' keeps both readys low through reset and the release cycle.
  always_comb begin
    pop             = (count != '0) && !in_ctrl_hold;
    room            = active && ((count != FULL) || pop);
    grant_alu       = in_alu_valid && (!in_mem_valid || last_mem);
    grant_mem       = in_mem_valid && !grant_alu;
    out_alu_ready   = grant_alu && room;
    out_mem_ready   = grant_mem && room;
    enq             = out_alu_ready || out_mem_ready;
    enq_rd          = grant_alu ? in_alu_rd  : in_mem_rd;
    enq_val         = grant_alu ? in_alu_val : in_mem_val;
    out_ctrl_regwrt = pop;
    out_rd          = (count != '0) ? rd_q[rptr]  : '0;
    out_rdval       = (count != '0) ? val_q[rptr] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr     <= '0;
      wptr     <= '0;
      count    <= '0;
      last_mem <= 1'b1;
      active   <= 1'b0;
    end else begin
      active <= 1'b1;
      if (enq) begin
        wptr     <= wptr + PTR_W'(1);
        last_mem <= grant_mem;
      end
      if (pop) rptr <= rptr + PTR_W'(1);
      if (enq && !pop)      count <= count + CNT_W'(1);
      else if (!enq && pop) count <= count - CNT_W'(1);
    end
  end

  // Payload storage needs no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (enq) begin
      rd_q[wptr]  <= enq_rd;
      val_q[wptr] <= enq_val;
    end
  end

  wbq_match #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W)
`ifdef WBQ_FORWARD_EN
    , .DATA_W(DATA_W)
`endif
  ) u_match_rs (
    .rd_q(rd_q),
`ifdef WBQ_FORWARD_EN
    .val_q(val_q),
    .fwd(out_rs_fwd),
`endif
    .rptr(rptr), .count(count), .index(in_rs), .pending(out_rs_pending)
  );

  wbq_match #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W)
`ifdef WBQ_FORWARD_EN
    , .DATA_W(DATA_W)
`endif
  ) u_match_rt (
    .rd_q(rd_q),
`ifdef WBQ_FORWARD_EN
    .val_q(val_q),
    .fwd(out_rt_fwd),
`endif
    .rptr(rptr), .count(count), .index(in_rt), .pending(out_rt_pending)
  );

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue: per-cycle vector table plus sequences
// for mid-operation reset and pointer wrap under alternating hold.
module tb_writeback_queue;
  import writeback_queue_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_alu_valid, in_mem_valid, in_ctrl_hold;
  logic [5:0]  in_alu_rd, in_mem_rd, in_rs, in_rt;
  logic [31:0] in_alu_val, in_mem_val;
  logic        out_alu_ready, out_mem_ready, out_ctrl_regwrt;
  logic [5:0]  out_rd;
  logic [31:0] out_rdval;
  logic        out_rs_pending, out_rt_pending;
`ifdef WBQ_FORWARD_EN
  logic [31:0] out_rs_fwd, out_rt_fwd;
`endif

  int checks = 0;
  int errors = 0;

  writeback_queue dut (
    .clk(clk), .rst_n(rst_n),
    .in_alu_valid(in_alu_valid), .in_alu_rd(in_alu_rd), .in_alu_val(in_alu_val),
    .out_alu_ready(out_alu_ready),
    .in_mem_valid(in_mem_valid), .in_mem_rd(in_mem_rd), .in_mem_val(in_mem_val),
    .out_mem_ready(out_mem_ready),
    .in_ctrl_hold(in_ctrl_hold),
    .out_ctrl_regwrt(out_ctrl_regwrt), .out_rd(out_rd), .out_rdval(out_rdval),
    .in_rs(in_rs), .in_rt(in_rt),
`ifdef WBQ_FORWARD_EN
    .out_rs_fwd(out_rs_fwd), .out_rt_fwd(out_rt_fwd),
`endif
    .out_rs_pending(out_rs_pending), .out_rt_pending(out_rt_pending)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic av; logic [5:0] ard; logic [31:0] aval;
    logic mv; logic [5:0] mrd; logic [31:0] mval;
    logic hold; logic [5:0] rs; logic [5:0] rt;
    logic e_ar; logic e_mr; logic e_wr; logic [5:0] e_rd; logic [31:0] e_val;
    logic e_rsp; logic e_rtp;
  } vec_t;

  vec_t tbl[$];
  wb_entry_t exp_q[$];

  function automatic vec_t mk(
    input logic av, input logic [5:0] ard, input logic [31:0] aval,
    input logic mv, input logic [5:0] mrd, input logic [31:0] mval,
    input logic hold, input logic [5:0] rs, input logic [5:0] rt,
    input logic e_ar, input logic e_mr, input logic e_wr, input logic [5:0] e_rd,
    input logic [31:0] e_val, input logic e_rsp, input logic e_rtp);
    vec_t v;
    v.av = av; v.ard = ard; v.aval = aval; v.mv = mv; v.mrd = mrd; v.mval = mval;
    v.hold = hold; v.rs = rs; v.rt = rt;
    v.e_ar = e_ar; v.e_mr = e_mr; v.e_wr = e_wr; v.e_rd = e_rd; v.e_val = e_val;
    v.e_rsp = e_rsp; v.e_rtp = e_rtp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input vec_t v);
    in_alu_valid = v.av; in_alu_rd = v.ard; in_alu_val = v.aval;
    in_mem_valid = v.mv; in_mem_rd = v.mrd; in_mem_val = v.mval;
    in_ctrl_hold = v.hold; in_rs = v.rs; in_rt = v.rt;
  endtask

  task automatic idle();
    in_alu_valid = 0; in_alu_rd = 0; in_alu_val = 0;
    in_mem_valid = 0; in_mem_rd = 0; in_mem_val = 0;
    in_ctrl_hold = 0; in_rs = 0; in_rt = 0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " alu_ready"}, 64'(out_alu_ready), 64'd0);
    chk({tag, " mem_ready"}, 64'(out_mem_ready), 64'd0);
    chk({tag, " regwrt"}, 64'(out_ctrl_regwrt), 64'd0);
    chk({tag, " rd"}, 64'(out_rd), 64'd0);
    chk({tag, " rdval"}, 64'(out_rdval), 64'd0);
    chk({tag, " rs_pend"}, 64'(out_rs_pending), 64'd0);
    chk({tag, " rt_pend"}, 64'(out_rt_pending), 64'd0);
  endtask

  initial begin
    // row order: alu(v,rd,val) mem(v,rd,val) hold rs rt | exp ar mr wr rd val rsp rtp
    tbl.push_back(mk(1, 1,'h101, 1,10,'h10a, 0, 1,10, 1,0,0, 0,0,      0,0));
    tbl.push_back(mk(1, 2,'h102, 1,10,'h10a, 0, 1,10, 0,1,1, 1,'h101,  1,0));
    tbl.push_back(mk(1, 2,'h102, 1,11,'h10b, 0, 1,10, 1,0,1,10,'h10a,  0,1));
    tbl.push_back(mk(1, 3,'h103, 1,11,'h10b, 0, 1,10, 0,1,1, 2,'h102,  0,0));
    tbl.push_back(mk(1, 3,'h103, 1,12,'h10c, 0, 1,10, 1,0,1,11,'h10b,  0,0));
    tbl.push_back(mk(0, 0,0,     1,12,'h10c, 0, 1,10, 0,1,1, 3,'h103,  0,0));
    tbl.push_back(mk(0, 0,0,     0, 0,0,     0, 1,10, 0,0,1,12,'h10c,  0,0));
    tbl.push_back(mk(0, 0,0,     0, 0,0,     0, 1,10, 0,0,0, 0,0,      0,0));
    tbl.push_back(mk(1, 5,'hdead,0, 0,0,     0, 5, 0, 1,0,0, 0,0,      0,0));
    tbl.push_back(mk(0, 0,0,     0, 0,0,     0, 5, 0, 0,0,1, 5,'hdead, 1,0));
    tbl.push_back(mk(0, 0,0,     0, 0,0,     0, 5, 0, 0,0,0, 0,0,      0,0));
    tbl.push_back(mk(1, 7,1,     0, 0,0,     1, 7, 8, 1,0,0, 0,0,      0,0));
    tbl.push_back(mk(1, 7,2,     0, 0,0,     1, 7, 8, 1,0,0, 7,1,      1,0));
    tbl.push_back(mk(0, 0,0,     0, 0,0,     1, 7, 8, 0,0,0, 7,1,      1,0));
    tbl.push_back(mk(0, 0,0,     0, 0,0,     0, 7, 8, 0,0,1, 7,1,      1,0));
    tbl.push_back(mk(0, 0,0,     0, 0,0,     0, 7, 8, 0,0,1, 7,2,      1,0));
    tbl.push_back(mk(0, 0,0,     0, 0,0,     0, 7, 8, 0,0,0, 0,0,      0,0));
    tbl.push_back(mk(1, 0,'h55,  0, 0,0,     0, 0, 0, 1,0,0, 0,0,      0,0));
    tbl.push_back(mk(0, 0,0,     0, 0,0,     0, 0, 0, 0,0,1, 0,'h55,   1,1));
    tbl.push_back(mk(0, 0,0,     0, 0,0,     0, 0, 0, 0,0,0, 0,0,      0,0));
    tbl.push_back(mk(1,20,'h1014,0, 0,0,     1,20,24, 1,0,0, 0,0,      0,0));
    tbl.push_back(mk(1,21,'h1015,0, 0,0,     1,20,24, 1,0,0,20,'h1014, 1,0));
    tbl.push_back(mk(1,22,'h1016,0, 0,0,     1,20,24, 1,0,0,20,'h1014, 1,0));
    tbl.push_back(mk(1,23,'h1017,0, 0,0,     1,20,24, 1,0,0,20,'h1014, 1,0));
    tbl.push_back(mk(1,24,'h1018,0, 0,0,     1,20,24, 0,0,0,20,'h1014, 1,0));
    tbl.push_back(mk(1,24,'h1018,0, 0,0,     0,20,24, 1,0,1,20,'h1014, 1,0));
    tbl.push_back(mk(0, 0,0,     0, 0,0,     0,20,24, 0,0,1,21,'h1015, 0,1));
    tbl.push_back(mk(0, 0,0,     0, 0,0,     0,20,24, 0,0,1,22,'h1016, 0,1));
    tbl.push_back(mk(0, 0,0,     0, 0,0,     0,20,24, 0,0,1,23,'h1017, 0,1));
    tbl.push_back(mk(0, 0,0,     0, 0,0,     0,20,24, 0,0,1,24,'h1018, 0,1));
    tbl.push_back(mk(0, 0,0,     0, 0,0,     0,20,24, 0,0,0, 0,0,      0,0));

    // reset state, with an ALU request already offered
    idle();
    rst_n = 1'b0;
    in_alu_valid = 1; in_alu_rd = 9; in_alu_val = 'h99;
    #2 chk_quiet("reset");
    @(posedge clk); #1 chk_quiet("reset_edge");
    rst_n = 1'b1;
    #3 chk("release alu_ready", 64'(out_alu_ready), 64'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk); #1 drive(tbl[i]);
      #3;
      chk($sformatf("row%0d alu_ready", i), 64'(out_alu_ready), 64'(tbl[i].e_ar));
      chk($sformatf("row%0d mem_ready", i), 64'(out_mem_ready), 64'(tbl[i].e_mr));
      chk($sformatf("row%0d regwrt", i), 64'(out_ctrl_regwrt), 64'(tbl[i].e_wr));
      chk($sformatf("row%0d rd", i), 64'(out_rd), 64'(tbl[i].e_rd));
      chk($sformatf("row%0d rdval", i), 64'(out_rdval), 64'(tbl[i].e_val));
      chk($sformatf("row%0d rs_pend", i), 64'(out_rs_pending), 64'(tbl[i].e_rsp));
      chk($sformatf("row%0d rt_pend", i), 64'(out_rt_pending), 64'(tbl[i].e_rtp));
`ifdef WBQ_FORWARD_EN
      if (i == 13) begin
        chk("row13 rs_fwd", 64'(out_rs_fwd), 64'd2);
        chk("row13 rt_fwd", 64'(out_rt_fwd), 64'd0);
      end
`endif
    end

    // reset with three entries queued
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1 idle();
      in_ctrl_hold = 1; in_alu_valid = 1; in_alu_rd = 6'(30 + k); in_alu_val = 32'(k);
    end
    @(posedge clk); #1 idle();
    in_rs = 30; in_rt = 32;
    #1 chk("pre-reset regwrt", 64'(out_ctrl_regwrt), 64'd1);
    chk("pre-reset rt_pend", 64'(out_rt_pending), 64'd1);
    in_alu_valid = 1; in_alu_rd = 33;
    #1 rst_n = 1'b0;
    in_rs = 0; in_rt = 0;
    #1 chk_quiet("midreset");
    in_rs = 30; in_rt = 32;
    #0.5;
    chk("midreset rs_pend30", 64'(out_rs_pending), 64'd0);
    chk("midreset rt_pend32", 64'(out_rt_pending), 64'd0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    in_alu_valid = 0;
    for (int k = 0; k < 4; k++) begin
      #3 chk($sformatf("postreset%0d regwrt", k), 64'(out_ctrl_regwrt), 64'd0);
      chk($sformatf("postreset%0d rs_pend", k), 64'(out_rs_pending), 64'd0);
      @(posedge clk); #1;
    end

    // pointer wrap: 10 ALU writes, hold alternating, scoreboard drain order
    begin
      int sent = 0;
      int got = 0;
      bit need_new = 1;
      logic exp_wr, exp_rdy;
      wb_entry_t cur, e;
      exp_q.delete();
      for (int cyc = 0; cyc < 200 && got < 10; cyc++) begin
        @(posedge clk); #1;
        if (need_new && sent < 10) begin
          cur.rd = 6'(40 + sent);
          cur.val = $urandom;
          need_new = 0;
        end
        in_alu_valid = (sent < 10);
        in_alu_rd = cur.rd; in_alu_val = cur.val;
        in_mem_valid = 0; in_ctrl_hold = cyc[0];
        #3;
        exp_wr = (exp_q.size() != 0) && !in_ctrl_hold;
        exp_rdy = in_alu_valid && ((exp_q.size() < 4) || exp_wr);
        chk($sformatf("wrap c%0d regwrt", cyc), 64'(out_ctrl_regwrt), 64'(exp_wr));
        chk($sformatf("wrap c%0d alu_ready", cyc), 64'(out_alu_ready), 64'(exp_rdy));
        if (out_ctrl_regwrt && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk($sformatf("wrap drain%0d rd", got), 64'(out_rd), 64'(e.rd));
          chk($sformatf("wrap drain%0d val", got), 64'(out_rdval), 64'(e.val));
          got++;
        end
        if (in_alu_valid && out_alu_ready) begin
          exp_q.push_back(cur);
          sent++;
          need_new = 1;
        end
      end
      chk("wrap drained count", 64'(got), 64'd10);
    end

    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 Parameter DEPTH, default 4, meaning number of buffered register writes (power of two, at least 2).
REQ-002 Parameter DATA_W, default 32, meaning register value width.
REQ-003 Parameter ADDR_W, default 6, meaning register index width (64 registers).
REQ-004 Port clk  input  1  single clock; all state changes on posedge.
REQ-005 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Ports in_alu_valid/in_alu_rd/in_alu_val  input  1/ADDR_W/DATA_W  ALU result write request.
REQ-007 Port out_alu_ready  output  1  ALU request accepted this edge when valid and ready.
REQ-008 Ports in_mem_valid/in_mem_rd/in_mem_val  input  1/ADDR_W/DATA_W  load result write request.
REQ-009 Port out_mem_ready  output  1  load request accepted this edge when valid and ready.
REQ-010 Port in_ctrl_hold  input  1  register-file write port unavailable; suppress drain.
REQ-011 Ports out_ctrl_regwrt/out_rd/out_rdval  output  1/ADDR_W/DATA_W  write port into the register file.
REQ-012 Ports in_rs/in_rt  input  ADDR_W each  hazard query indices.
REQ-013 Ports out_rs_pending/out_rt_pending  output  1 each  a queued write targets that index.

Function
REQ-014 Queue shall be a circular FIFO of DEPTH entries {rd, val}, read/write pointers wrapping modulo DEPTH, occupancy count 0..DEPTH.
REQ-015 At most one request shall be enqueued per edge.
REQ-016 Arbitration: one valid source wins; both valid -> source not granted last shall win (round-robin); last-grant flop updates only on an actual enqueue.
REQ-017 out_x_ready shall be 1 only for the arbitration winner and only when count < DEPTH, or count == DEPTH with a drain occurring this cycle.
REQ-018 Drain: out_ctrl_regwrt = (count != 0) && !in_ctrl_hold, combinational; out_rd/out_rdval = head entry, zeros when empty.
REQ-019 Head shall pop on the edge where out_ctrl_regwrt is 1; an entry enqueued at edge N is presented at earliest during cycle N+1 (write lands in register file at edge N+1).
REQ-020 Simultaneous enqueue and pop shall leave count unchanged; entries shall drain strictly in acceptance order.
REQ-021 No enqueue to an empty queue shall bypass the FIFO; empty-cycle writes are never issued.
REQ-022 out_rs_pending/out_rt_pending shall be combinational OR over occupied entries of (rd == index); the entry being popped this cycle still counts.
REQ-023 Index 0 shall receive no special treatment.
REQ-024 No request shall be dropped or duplicated; a valid request not accepted must be held stable by its source.

Reset
REQ-025 rst_n low shall asynchronously clear pointers and count to 0, last-grant to "mem" (so ALU wins first tie), drive out_ctrl_regwrt 0, out_rd 0, out_rdval 0, both ready low, both pending 0.
REQ-026 Reset mid-operation shall discard all queued entries; no write issues on or after the asserting edge.
REQ-027 Ready outputs shall stay low while rst_n is low and may rise the first cycle after release.

Configuration
REQ-028 Macro WBQ_FORWARD_EN defined: add outputs out_rs_fwd/out_rt_fwd (DATA_W) giving the youngest matching queued value, zero when not pending.
REQ-029 WBQ_FORWARD_EN undefined: those ports absent; pending flags only, consumers stall.

Structure
REQ-030 Shared package holds ADDR_W, DATA_W defaults and the wb_entry typedef {rd, val}.
REQ-031 One sub-module, wbq_match, shall compute per-entry index match and youngest-match select for one query port; instantiated twice.

Verification
REQ-032 Reset release, ALU writes rd=5 val=0xDEAD -> regwrt=1, rd=5, rdval=0xDEAD next cycle, then queue empty.
REQ-033 Both sources valid three cycles (ALU rd=1,2,3; mem rd=10,11,12), hold=0 -> grant order ALU1, mem10, ALU2, mem11, ALU3, mem12.
REQ-034 hold=1, DEPTH=4, five ALU requests -> four accepted, ready low on fifth; release hold -> fifth accepted same edge as first pop.
REQ-035 Queue holds rd=7 twice (vals 1 then 2), query in_rs=7 -> rs_pending=1; with WBQ_FORWARD_EN out_rs_fwd=2; in_rt=8 -> rt_pending=0.
REQ-036 rst_n pulsed low with 3 entries queued -> regwrt 0 immediately, pending 0, no further writes.
REQ-037 Pointer wrap: 10 back-to-back writes with alternating hold -> all 10 drain in order, count never exceeds 4.
